// File: rtl/mux_scan_sequencer_pkg.sv
// Shared constants, FSM state type and select-range helpers for the
// mux scan sequencer and its select counter.
package mux_scan_sequencer_pkg;

  localparam int WIDTH = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // First select position of a byte for the given bit order.
  function automatic int unsigned start_idx(input bit msb_first, input int unsigned width);
    return msb_first ? (width - 1) : 0;
  endfunction

  // Last select position of a byte for the given bit order.
  function automatic int unsigned end_idx(input bit msb_first, input int unsigned width);
    return msb_first ? 0 : (width - 1);
  endfunction

endpackage

// File: rtl/mux_sel_counter.sv
// Up/down select counter for the external select tree. Load returns the
// count to its start position, enable steps it by one, and tc flags the
// end position so the owner can stop stepping there.
module mux_sel_counter #(
  parameter int               SEL_W      = 3,
  parameter bit               COUNT_DOWN = 1'b0,
  parameter logic [SEL_W-1:0] START_VAL  = '0,
  parameter logic [SEL_W-1:0] END_VAL    = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  output logic [SEL_W-1:0] count,
  output logic             tc
);

  logic [SEL_W-1:0] count_next;

  // Direction is fixed at elaboration, so only one adder/subtractor exists.
  generate
    if (COUNT_DOWN) begin : g_down
      assign count_next = count - SEL_W'(1);
    end else begin : g_up
      assign count_next = count + SEL_W'(1);
    end
  endgenerate

  assign tc = (count == END_VAL);

  // Load has priority over stepping; the owner never enables at END_VAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= START_VAL;
    end else if (load) begin
      count <= START_VAL;
    end else if (en) begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Control stage in front of an external WIDTH:1 select tree. A byte taken
// over the input handshake is held on the mux data inputs while the select
// walks every position; the mux output comes back on mux_y and is forwarded
// as a serial stream with valid/ready/last.
module mux_scan_sequencer #(
  parameter int WIDTH     = mux_scan_sequencer_pkg::WIDTH,
  parameter int SEL_W     = mux_scan_sequencer_pkg::SEL_W,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] mux_i,
  output logic [SEL_W-1:0] mux_s,
  input  logic             mux_y,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_bit,
  output logic             ser_last,
  input  logic             abort
);

  import mux_scan_sequencer_pkg::*;

  localparam logic [SEL_W-1:0] START_SEL = SEL_W'(start_idx(MSB_FIRST, WIDTH));
  localparam logic [SEL_W-1:0] END_SEL   = SEL_W'(end_idx(MSB_FIRST, WIDTH));

  state_t state_reg;
  logic   at_end;
  logic   load_hs;
  logic   bit_hs;
  logic   byte_done;
  logic   sel_load;
  logic   sel_step;

  // Serial side is a direct view of the FSM state and the select position;
  // the data bit itself is the combinational return from the external mux.
  assign ser_valid = (state_reg == SHIFT);
  assign ser_last  = ser_valid & at_end;
  assign ser_bit   = mux_y;

  // A new byte may enter while idle, or on the final bit of the current byte
  // so back-to-back bytes stream without a bubble. Abort blocks any load.
  assign in_ready  = ~abort & (~ser_valid | (ser_last & ser_ready));

  assign load_hs   = in_valid & in_ready;
  assign bit_hs    = ser_valid & ser_ready;
  assign byte_done = bit_hs & ser_last;

  // The select is parked at the start position whenever a byte ends, a new
  // byte loads or an abort flushes; it only steps on an accepted non-final bit.
  assign sel_load  = abort | load_hs | byte_done;
  assign sel_step  = bit_hs & ~ser_last;

  mux_sel_counter #(
    .SEL_W     (SEL_W),
    .COUNT_DOWN(MSB_FIRST),
    .START_VAL (START_SEL),
    .END_VAL   (END_SEL)
  ) u_sel_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .load (sel_load),
    .en   (sel_step),
    .count(mux_s),
    .tc   (at_end)
  );

  // Byte capture and IDLE/SHIFT sequencing; abort outranks everything but reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      mux_i     <= '0;
    end else if (abort) begin
      state_reg <= IDLE;
    end else if (load_hs) begin
      state_reg <= SHIFT;
      mux_i     <= in_data;
    end else if (byte_done) begin
      state_reg <= IDLE;
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: one LSB-first and one MSB-first instance,
// each with its own behavioural 8:1 mux, share the same stimulus and are
// compared every cycle against a byte/bit-position reference model.
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       ser_ready = 1'b0;
  logic       abort = 1'b0;

  logic       in_ready_l, ser_valid_l, ser_bit_l, ser_last_l, mux_y_l;
  logic [7:0] mux_i_l;
  logic [2:0] mux_s_l;
  logic       in_ready_m, ser_valid_m, ser_bit_m, ser_last_m, mux_y_m;
  logic [7:0] mux_i_m;
  logic [2:0] mux_s_m;

  int n_vec = 0;
  int n_err = 0;

  // reference model: a byte in flight and how many of its bits were taken
  bit       busy = 1'b0;
  int       k = 0;
  bit [7:0] cur = '0;
  bit       parked = 1'b1;

  always #5 clk = ~clk;

  // external 8:1 select trees
  assign mux_y_l = mux_i_l[mux_s_l];
  assign mux_y_m = mux_i_m[mux_s_m];

  mux_scan_sequencer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l),
    .in_data(in_data), .mux_i(mux_i_l), .mux_s(mux_s_l), .mux_y(mux_y_l),
    .ser_valid(ser_valid_l), .ser_ready(ser_ready), .ser_bit(ser_bit_l),
    .ser_last(ser_last_l), .abort(abort)
  );

  mux_scan_sequencer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_data(in_data), .mux_i(mux_i_m), .mux_s(mux_s_m), .mux_y(mux_y_m),
    .ser_valid(ser_valid_m), .ser_ready(ser_ready), .ser_bit(ser_bit_m),
    .ser_last(ser_last_m), .abort(abort)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive at the falling edge, check 1 ns later, advance the model.
  task automatic step(input logic rst, input logic iv, input logic [7:0] id,
                      input logic sr, input logic ab);
    bit exp_ready;
    bit accept;
    @(negedge clk);
    rst_n = rst; in_valid = iv; in_data = id; ser_ready = sr; abort = ab;
    #1;
    if (!rst) begin
      busy = 1'b0; k = 0; cur = '0; parked = 1'b1;
    end
    exp_ready = !ab && (!busy || (k == 7 && sr));
    check("in_ready_l", {7'd0, in_ready_l}, {7'd0, exp_ready});
    check("in_ready_m", {7'd0, in_ready_m}, {7'd0, exp_ready});
    check("ser_valid_l", {7'd0, ser_valid_l}, {7'd0, busy});
    check("ser_valid_m", {7'd0, ser_valid_m}, {7'd0, busy});
    check("ser_last_l", {7'd0, ser_last_l}, {7'd0, busy && k == 7});
    check("ser_last_m", {7'd0, ser_last_m}, {7'd0, busy && k == 7});
    check("mux_i_l", mux_i_l, cur);
    check("mux_i_m", mux_i_m, cur);
    if (busy) begin
      check("ser_bit_l", {7'd0, ser_bit_l}, {7'd0, cur[k]});
      check("ser_bit_m", {7'd0, ser_bit_m}, {7'd0, cur[7-k]});
      check("mux_s_l", {5'd0, mux_s_l}, 8'(k));
      check("mux_s_m", {5'd0, mux_s_m}, 8'(7 - k));
    end else if (parked) begin
      check("mux_s_l_idle", {5'd0, mux_s_l}, 8'd0);
      check("mux_s_m_idle", {5'd0, mux_s_m}, 8'd7);
    end
    if (rst) begin
      if (ab) begin
        busy = 1'b0; k = 0; parked = 1'b1;
      end else begin
        accept = iv && exp_ready;
        if (busy && sr) begin
          if (k == 7) busy = 1'b0;
          else k++;
        end
        if (accept) begin
          busy = 1'b1; cur = id; k = 0; parked = 1'b0;
        end
      end
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    bit r, a, v, s;
    // reset state
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    idle_steps(1);

    // single bytes: 8'h40 and 8'h80 in both bit orders
    step(1'b1, 1'b1, 8'h40, 1'b1, 1'b0);
    idle_steps(9);
    step(1'b1, 1'b1, 8'h80, 1'b1, 1'b0);
    idle_steps(9);

    // stall three cycles at bit position 3 of 8'h08
    step(1'b1, 1'b1, 8'h08, 1'b1, 1'b0);
    idle_steps(3);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    idle_steps(6);

    // back-to-back A5 then 3C with in_valid held
    step(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'h3C, 1'b1, 1'b0);
    idle_steps(9);

    // asynchronous reset at bit position 4 of 8'hFF
    step(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
    idle_steps(4);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
    idle_steps(9);

    // abort at bit position 5 with a competing load, then a normal load
    step(1'b1, 1'b1, 8'hB6, 1'b1, 1'b0);
    idle_steps(5);
    step(1'b1, 1'b1, 8'hE7, 1'b1, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'hC3, 1'b1, 1'b0);
    idle_steps(9);

    // randomized traffic with stalls, aborts and occasional resets
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 199) != 0);
      a = r && ($urandom_range(0, 39) == 0);
      v = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 3) != 0);
      step(r, v, 8'($urandom), s, a);
    end
    idle_steps(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
